// File: rtl/sccb_master.sv
// sccb_master: SCCB/I2C master for camera register configuration.
// Does 3-phase writes and SCCB 2-phase reads (address write, STOP, GAP, START,
// read byte). Everything runs on clk; bus timing comes from a quarter-period
// tick enable rather than a derived clock.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_rw/id/reg/wdata      command fields, latched on accept
//   rsp_valid/rdata/nack     one-cycle completion pulse plus result
//   busy                     ~cmd_ready
//   sioc_o                   SIOC, push-pull
//   siod_oe/siod_i           open-drain SIOD: oe=1 pulls low, siod_i is the pad
module sccb_master #(
  parameter int DIV       = 250,
  parameter int REG_W     = 8,
  parameter int CHECK_ACK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_id,
  input  logic [REG_W-1:0] cmd_reg,
  input  logic [7:0]       cmd_wdata,
  output logic             rsp_valid,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_nack,
  output logic             busy,
  output logic             sioc_o,
  output logic             siod_oe,
  input  logic             siod_i
);

  localparam int RB = REG_W / 8;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, BYTE, STOP, GAP, RESP} state_t;

  state_t       st, st_n;
  logic [DW-1:0] div;
  logic [1:0]   q, q_n;
  logic [3:0]   bitn, bit_n;
  logic [1:0]   byten, byte_n;
  logic         phase, phase_n;
  logic [7:0]   sh, sh_n;
  logic         nack, nack_n;
  logic         sioc_n, oe_n;
  logic         rw_q;
  logic [6:0]   id_q;
  logic [15:0]  reg_q;
  logic [7:0]   wd_q;
  logic         tick, rd_byte;
  logic [1:0]   last;

  assign tick      = (div == DW'(DIV - 1));
  assign cmd_ready = (st == IDLE);
  assign busy      = ~cmd_ready;
  // Second byte of the read phase is the slave's data; its 9th bit is ours.
  assign rd_byte   = phase & (byten == 2'd1);
  assign last      = phase ? 2'd1 : (rw_q ? 2'(RB) : 2'(RB + 1));

  // Byte to shift out at index idx of the current phase. The read data byte
  // is loaded as all ones so SIOD stays released while the slave drives it;
  // sampled bits shift in behind it, leaving the received byte in sh.
  function automatic logic [7:0] byte_at(input logic ph, input logic [1:0] idx);
    if (idx == 2'd0)             return {id_q, ph};
    if (ph)                      return 8'hFF;
    if (idx == 2'(RB + 1))       return wd_q;
    if (RB == 2 && idx == 2'd1)  return reg_q[15:8];
    return reg_q[7:0];
  endfunction

  always_comb begin
    st_n    = st;
    q_n     = q;
    bit_n   = bitn;
    byte_n  = byten;
    phase_n = phase;
    sh_n    = sh;
    nack_n  = nack;
    case (st)
      IDLE: if (cmd_valid) begin
        st_n = START; q_n = 2'd0; phase_n = 1'b0; nack_n = 1'b0;
      end
      RESP: st_n = IDLE;
      default: if (tick) begin
        q_n = q + 2'd1;
        if (q == 2'd3) begin
          case (st)
            START: begin
              st_n = BYTE; bit_n = 4'd0; byte_n = 2'd0; sh_n = byte_at(phase, 2'd0);
            end
            BYTE: begin
              if (bitn != 4'd8) begin
                sh_n  = {sh[6:0], siod_i};
                bit_n = bitn + 4'd1;
              end else if (CHECK_ACK != 0 && !rd_byte && siod_i) begin
                nack_n = 1'b1; st_n = STOP;
              end else if (byten == last) begin
                st_n = STOP;
              end else begin
                byte_n = byten + 2'd1;
                bit_n  = 4'd0;
                sh_n   = byte_at(phase, byten + 2'd1);
              end
            end
            STOP:    st_n = (!phase && rw_q && !nack) ? GAP : RESP;
            GAP:     begin st_n = START; phase_n = 1'b1; end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Pad levels for the quarter being entered, so the pins come straight from flops.
  always_comb begin
    sioc_n = 1'b1;
    oe_n   = 1'b0;
    case (st_n)
      START: oe_n = q_n[1];
      BYTE: begin
        sioc_n = q_n[1];
        oe_n   = (bit_n != 4'd8) & ~sh_n[7];
      end
      STOP: begin
        sioc_n = q_n[1];
        oe_n   = (q_n != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE; div <= '0; q <= 2'd0; bitn <= 4'd0; byten <= 2'd0;
      phase <= 1'b0; sh <= 8'h00; nack <= 1'b0;
      sioc_o <= 1'b1; siod_oe <= 1'b0;
      rsp_valid <= 1'b0; rsp_rdata <= 8'h00; rsp_nack <= 1'b0;
      rw_q <= 1'b0; id_q <= 7'h00; reg_q <= 16'h0000; wd_q <= 8'h00;
    end else begin
      st <= st_n; q <= q_n; bitn <= bit_n; byten <= byte_n;
      phase <= phase_n; sh <= sh_n; nack <= nack_n;
      sioc_o <= sioc_n; siod_oe <= oe_n;
      div <= (st == IDLE || tick) ? '0 : div + 1'b1;
      if (st == IDLE && cmd_valid) begin
        rw_q <= cmd_rw; id_q <= cmd_id; reg_q <= 16'(cmd_reg); wd_q <= cmd_wdata;
      end
      rsp_valid <= 1'b0;
      if (st != RESP && st_n == RESP) begin
        rsp_valid <= 1'b1;
        rsp_nack  <= nack_n;
        rsp_rdata <= (rw_q && !nack_n) ? sh_n : 8'h00;
      end
    end
  end

endmodule
